// File: rtl/yascm_pkg.sv
// Shared encodings for the multi-cycle yascm core: opcodes, functs, FSM states, ALU ops.
package yascm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        AND,
        OR,
        SLT
    } alu_op_e;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_op_e funct_alu_op(input logic [5:0] funct);
        alu_op_e op;
        op = ADD;
        case (funct)
            FN_SUB:  op = SUB;
            FN_AND:  op = AND;
            FN_OR:   op = OR;
            FN_SLT:  op = SLT;
            default: op = ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/yascm_regfile.sv
// 32x32 register file, two async read ports and one sync write port; $0 reads as zero.
// Write lands on the clock edge and is visible to reads in the following cycle.
module yascm_regfile (
    input  logic        clk,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    // No storage for $0: it is hardwired, so writes to it have nowhere to land.
    logic [31:0] r_mem [1:31];

    always_ff @(posedge clk) begin
        if (i_we && (i_wa != 5'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_mem[i_ra2];

endmodule

// File: rtl/yascm_mc.sv
// Multi-cycle MIPS-subset core: one shared ALU sequenced by a FETCH/DECODE/EXEC/MEM/WB FSM.
// 3-5 cycles per instruction at zero wait; each req is held, with stable address, until its ack.
module yascm_mc
    import yascm_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR       = 32'd0,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halted
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_alu_out;
    logic [31:0] r_mdr;
    logic [31:0] r_instret;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_rf_rd1;
    logic [31:0] w_rf_rd2;
    logic        w_rf_we;
    logic [4:0]  w_rf_wa;
    logic [31:0] w_rf_wd;

    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    alu_op_e     w_alu_op;
    logic [31:0] w_alu_y;

    logic        w_illegal;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_beq_taken;
    logic        w_retire;
    logic        w_imem_req;
    logic        w_dmem_req;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];

    assign w_illegal   = !is_legal(w_op, w_funct);
    assign w_mem_op    = (w_op == OP_LW) || (w_op == OP_SW);
    assign w_misalign  = w_mem_op && (w_alu_y[1:0] != 2'b00);
    assign w_beq_taken = (r_a == r_b);

    yascm_regfile u_regfile (
        .clk   (clk),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rf_rd1),
        .o_rd2 (w_rf_rd2),
        .i_we  (w_rf_we),
        .i_wa  (w_rf_wa),
        .i_wd  (w_rf_wd)
    );

    assign w_rf_we = (r_state == WB) && !rst;
    assign w_rf_wa = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_rf_wd = (w_op == OP_LW) ? r_mdr : r_alu_out;

    // Shared ALU: pc+4 in FETCH, branch target / address / result in EXEC.
    always_comb begin
        w_alu_a  = r_a;
        w_alu_b  = r_b;
        w_alu_op = ADD;
        case (r_state)
            FETCH: begin
                w_alu_a = r_pc;
                w_alu_b = 32'd4;
            end
            EXEC: begin
                case (w_op)
                    OP_RTYPE: w_alu_op = funct_alu_op(w_funct);
                    OP_BEQ: begin
                        w_alu_a = r_pc;
                        w_alu_b = {r_imm[29:0], 2'b00};
                    end
                    default: w_alu_b = r_imm;
                endcase
            end
            default: ;
        endcase

        case (w_alu_op)
            ADD:     w_alu_y = w_alu_a + w_alu_b;
            SUB:     w_alu_y = w_alu_a - w_alu_b;
            AND:     w_alu_y = w_alu_a & w_alu_b;
            OR:      w_alu_y = w_alu_a | w_alu_b;
            SLT:     w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            default: w_alu_y = w_alu_a + w_alu_b;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (!w_illegal) begin
                    w_state_nxt = EXEC;
                end else if (HALT_ON_ILLEGAL) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = FETCH;
                    w_retire    = 1'b1;
                end
            end
            EXEC: begin
                case (w_op)
                    OP_BEQ, OP_J: begin
                        w_state_nxt = FETCH;
                        w_retire    = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        if (!w_misalign) begin
                            w_state_nxt = MEM;
                        end else if (HALT_ON_ILLEGAL) begin
                            w_state_nxt = HALT;
                        end else begin
                            w_state_nxt = FETCH;
                            w_retire    = 1'b1;
                        end
                    end
                    default: w_state_nxt = WB;
                endcase
            end
            MEM: begin
                w_dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (w_op == OP_SW) begin
                        w_state_nxt = FETCH;
                        w_retire    = 1'b1;
                    end else begin
                        w_state_nxt = WB;
                    end
                end
            end
            WB: begin
                w_state_nxt = FETCH;
                w_retire    = 1'b1;
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_pc      <= BOOT_ADDR;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_imm     <= 32'd0;
            r_alu_out <= 32'd0;
            r_mdr     <= 32'd0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_ir <= imem_rdata;
                        r_pc <= w_alu_y;
                    end
                end
                DECODE: begin
                    r_a   <= w_rf_rd1;
                    r_b   <= w_rf_rd2;
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                end
                EXEC: begin
                    case (w_op)
                        OP_BEQ: begin
                            if (w_beq_taken) begin
                                r_pc <= w_alu_y;
                            end
                        end
                        // pc already points past the jump, so its top nibble is the new region.
                        OP_J:    r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        default: r_alu_out <= w_alu_y;
                    endcase
                end
                MEM: begin
                    if (dmem_ack && (w_op == OP_LW)) begin
                        r_mdr <= dmem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = w_imem_req && !rst;
    assign imem_addr  = r_pc;
    assign dmem_req   = w_dmem_req && !rst;
    assign dmem_we    = (r_state == MEM) && (w_op == OP_SW) && !rst;
    assign dmem_addr  = r_alu_out;
    assign dmem_wdata = r_b;
    assign retire     = w_retire && !rst;
    assign instret    = r_instret;
    assign halted     = (r_state == HALT) && !rst;

endmodule

// File: tb/tb_yascm_mc.sv
// Directed bench for yascm_mc: program-driven checks of results, latencies, handshakes and illegal handling.
module tb_yascm_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b1;
    logic rst0 = 1'b1;

    // Main instance: BOOT_ADDR=0x100, halts on illegal.
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, instret;

    // Second instance: BOOT_ADDR=0, illegal retires as NOP.
    logic        imem0_req, imem0_ack, dmem0_req, dmem0_we, dmem0_ack, retire0, halted0;
    logic [31:0] imem0_addr, imem0_rdata, dmem0_addr, dmem0_wdata, dmem0_rdata, instret0;

    yascm_mc #(.BOOT_ADDR(32'h100), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .instret(instret), .halted(halted)
    );

    yascm_mc #(.BOOT_ADDR(32'h0), .HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst0),
        .imem_req(imem0_req), .imem_addr(imem0_addr), .imem_ack(imem0_ack), .imem_rdata(imem0_rdata),
        .dmem_req(dmem0_req), .dmem_we(dmem0_we), .dmem_addr(dmem0_addr), .dmem_wdata(dmem0_wdata),
        .dmem_ack(dmem0_ack), .dmem_rdata(dmem0_rdata),
        .retire(retire0), .instret(instret0), .halted(halted0)
    );

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    logic [31:0] imem0 [0:15];
    int icnt = 0;
    int dcnt = 0;
    int cyc  = 0;

    // Wait states: fetch of 0x40 waits 3 cycles, load from 0x20 waits 2.
    assign imem_ack   = imem_req && (icnt == ((imem_addr == 32'h40) ? 3 : 0));
    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_ack   = dmem_req && (dcnt == ((!dmem_we && dmem_addr == 32'h20) ? 2 : 0));
    assign dmem_rdata = dmem[dmem_addr[9:2]];

    assign imem0_ack   = imem0_req;
    assign imem0_rdata = imem0[imem0_addr[5:2]];
    assign dmem0_ack   = dmem0_req;
    assign dmem0_rdata = 32'd0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
    end

    int          lat_q [$];
    logic [31:0] fa_q [$];
    logic [31:0] sa_q [$];
    logic [31:0] sd_q [$];
    int          last_ret = 0;
    int          dreq_cnt = 0;
    int          viol     = 0;
    logic        p_ireq = 1'b0, p_dreq = 1'b0, p_dwe = 1'b0;
    logic [31:0] p_iaddr = '0, p_daddr = '0, p_dwdata = '0;

    int          rel0 = 0;
    logic        got0 = 1'b0;
    int          d0_cyc = 0;
    logic        d0_we = 1'b0;
    logic [31:0] d0_addr = '0, d0_wdata = '0, d0_instret = '0;

    always @(negedge clk) begin
        if (rst) begin
            last_ret = cyc;
            p_ireq   = 1'b0;
            p_dreq   = 1'b0;
        end else begin
            if (retire) begin
                lat_q.push_back(cyc - last_ret);
                last_ret = cyc;
            end
            if (imem_req && imem_ack) fa_q.push_back(imem_addr);
            if (dmem_req && dmem_ack && dmem_we) begin
                sa_q.push_back(dmem_addr);
                sd_q.push_back(dmem_wdata);
            end
            if (dmem_req) dreq_cnt++;
            if (imem_req && dmem_req) viol++;
            if (halted && (imem_req || dmem_req)) viol++;
            if (p_ireq && (!imem_req || imem_addr != p_iaddr)) viol++;
            if (p_dreq && (!dmem_req || dmem_addr != p_daddr || dmem_we != p_dwe || dmem_wdata != p_dwdata)) viol++;
            if (dmem_req && dmem_addr[1:0] != 2'b00) viol++;
            p_ireq   = imem_req && !imem_ack;
            p_iaddr  = imem_addr;
            p_dreq   = dmem_req && !dmem_ack;
            p_daddr  = dmem_addr;
            p_dwe    = dmem_we;
            p_dwdata = dmem_wdata;
        end
        if (rst0) begin
            rel0 = cyc;
        end else if (dmem0_req && !got0) begin
            got0       = 1'b1;
            d0_cyc     = cyc - rel0;
            d0_we      = dmem0_we;
            d0_addr    = dmem0_addr;
            d0_wdata   = dmem0_wdata;
            d0_instret = instret0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    int          exp_lat [16] = '{4, 4, 4, 4, 4, 5, 4, 4, 4, 3, 3, 3, 7, 7, 4, 4};
    logic [31:0] exp_sa [6]   = '{32'h8, 32'hC, 32'h10, 32'h20, 32'h24, 32'h28};
    logic [31:0] exp_sd [6]   = '{32'd2, 32'd2, 32'd1, 32'd5, 32'd10, 32'd5};

    initial begin
        int g;
        int d_before;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'd0;
            dmem[i] = 32'd0;
        end
        for (int i = 0; i < 16; i++) imem0[i] = 32'd0;

        imem[64] = enc_i(6'd8,  5'd0, 5'd1, 16'd5);          // 0x100 addi $1,$0,5
        imem[65] = enc_i(6'd8,  5'd0, 5'd2, 16'hFFFD);       // 0x104 addi $2,$0,-3
        imem[66] = enc_r(5'd1,  5'd2, 5'd3, 6'h20);          // 0x108 add  $3,$1,$2
        imem[67] = enc_r(5'd2,  5'd1, 5'd4, 6'h2A);          // 0x10C slt  $4,$2,$1
        imem[68] = enc_i(6'd43, 5'd0, 5'd3, 16'h8);          // 0x110 sw   $3,8($0)
        imem[69] = enc_i(6'd35, 5'd0, 5'd5, 16'h8);          // 0x114 lw   $5,8($0)
        imem[70] = enc_i(6'd43, 5'd0, 5'd5, 16'hC);          // 0x118 sw   $5,12($0)
        imem[71] = enc_i(6'd43, 5'd0, 5'd4, 16'h10);         // 0x11C sw   $4,16($0)
        imem[72] = enc_i(6'd43, 5'd0, 5'd1, 16'h20);         // 0x120 sw   $1,0x20($0)
        imem[73] = enc_i(6'd4,  5'd1, 5'd2, 16'd5);          // 0x124 beq  $1,$2,+5 (not taken)
        imem[74] = enc_i(6'd4,  5'd0, 5'd0, 16'hFFFF);       // 0x128 beq  $0,$0,-1 (taken)
        imem[16] = enc_r(5'd1,  5'd1, 5'd6, 6'h20);          // 0x40  add  $6,$1,$1
        imem[17] = enc_i(6'd35, 5'd0, 5'd7, 16'h20);         // 0x44  lw   $7,0x20($0)
        imem[18] = enc_i(6'd43, 5'd0, 5'd6, 16'h24);         // 0x48  sw   $6,0x24($0)
        imem[19] = enc_i(6'd43, 5'd0, 5'd7, 16'h28);         // 0x4C  sw   $7,0x28($0)
        imem[20] = 32'hFC00_0000;                            // 0x50  illegal op 0x3F

        imem0[0] = 32'hFC00_0000;                            // 0x0 illegal
        imem0[1] = enc_i(6'd35, 5'd0, 5'd5, 16'd6);          // 0x4 lw $5,6($0) misaligned
        imem0[2] = enc_i(6'd8,  5'd0, 5'd1, 16'd7);          // 0x8 addi $1,$0,7
        imem0[3] = enc_i(6'd43, 5'd0, 5'd1, 16'd0);          // 0xC sw $1,0($0)
        imem0[4] = enc_i(6'd4,  5'd0, 5'd0, 16'hFFFF);       // 0x10 beq loop

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instret", instret, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h100);
        repeat (16) @(negedge clk);
        check("instret_16cyc", instret, 32'd4);

        // Once the taken beq at 0x128 has been fetched, replace it with j 0x40 to leave the loop.
        g = 0;
        while (fa_q.size() < 11 && g < 200) begin
            @(negedge clk);
            g++;
        end
        imem[74] = {6'd2, 26'h10};

        g = 0;
        while (!halted && g < 400) begin
            @(negedge clk);
            g++;
        end
        check("halt_on_illegal", {31'd0, halted}, 32'd1);
        check("instret_final", instret, 32'd16);
        check("retire_count", lat_q.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < lat_q.size()) check($sformatf("lat_%0d", i), lat_q[i], exp_lat[i]);
        end
        check("fetch_count", fa_q.size(), 32'd17);
        if (fa_q.size() >= 17) begin
            check("fetch_beq_nt", fa_q[10], 32'h128);
            check("fetch_beq_t", fa_q[11], 32'h128);
            check("fetch_j", fa_q[12], 32'h40);
            check("fetch_after_j", fa_q[13], 32'h44);
            check("fetch_illegal", fa_q[16], 32'h50);
        end
        check("store_count", sa_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < sa_q.size()) begin
                check($sformatf("st_addr_%0d", i), sa_q[i], exp_sa[i]);
                check($sformatf("st_data_%0d", i), sd_q[i], exp_sd[i]);
            end
        end
        d_before = dreq_cnt;
        repeat (10) @(negedge clk);
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_no_dreq", dreq_cnt, d_before);
        check("halt_instret", instret, 32'd16);

        // Misaligned lw at boot with halting enabled.
        @(posedge clk); #1 rst = 1'b1;
        imem[64] = enc_i(6'd35, 5'd0, 5'd5, 16'd6);
        @(posedge clk); #1 rst = 1'b0;
        d_before = dreq_cnt;
        @(negedge clk);
        check("rst_clears_halt", {31'd0, halted}, 32'd0);
        check("refetch_addr", imem_addr, 32'h100);
        repeat (5) @(negedge clk);
        check("misalign_halt", {31'd0, halted}, 32'd1);
        check("misalign_instret", instret, 32'd0);
        check("misalign_no_dreq", dreq_cnt, d_before);

        // Non-halting instance: illegal and misaligned both retire as NOPs.
        @(posedge clk); #1 rst0 = 1'b0;
        repeat (3) @(negedge clk);
        check("nop_illegal_instret", instret0, 32'd1);
        g = 0;
        while (!got0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("nop_first_dreq_seen", {31'd0, got0}, 32'd1);
        check("nop_first_dreq_cyc", d0_cyc, 32'd13);
        check("nop_first_dreq_we", {31'd0, d0_we}, 32'd1);
        check("nop_store_addr", d0_addr, 32'd0);
        check("nop_store_data", d0_wdata, 32'd7);
        check("nop_instret_at_sw", d0_instret, 32'd3);
        check("nop_not_halted", {31'd0, halted0}, 32'd0);

        check("handshake_violations", viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yascm_mc.md
# yascm_mc

Multi-cycle successor to the single-cycle yascm core: a MIPS-subset CPU sequenced by a five-state FSM that shares one ALU across fetch, address generation and execute. It talks to instruction and data memory over req/ack handshakes, so it tolerates multi-cycle memories. It adds features the single-cycle core lacks:

- real PC control (beq, j);
- lw/sw through a data port;
- addi;
- configurable illegal-instruction handling;
- a retired-instruction counter.

## Interface
- BOOT_ADDR, 32'd0, PC value loaded on reset; must be word-aligned.
- HALT_ON_ILLEGAL, 1, 1: an illegal op/funct or a misaligned access enters HALT. 0: the instruction retires as a NOP.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  fetch done; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  byte address; always word-aligned.
- dmem_wdata  out  32  store data (rt).
- dmem_ack  in  1  access done; dmem_rdata is valid in the same cycle for loads.
- dmem_rdata  in  32  load data.
- retire  out  1  one-cycle pulse in the final cycle of each retired instruction.
- instret  out  32  count of retired instructions; wraps 0xFFFFFFFF→0.
- halted  out  1  sticky; high while in HALT.

## Operation

Supported instructions:
- R-type (op 0) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
- op 8 addi (sign-extended immediate).
- op 35 lw, op 43 sw.
- op 4 beq, op 2 j.
- Arithmetic wraps; no overflow traps.

Register file:
- 32×32 bits, two async read ports, one sync write port.
- $0 always reads 0; writes to $0 are dropped.

Destination register:
- rd for R-type.
- rt for addi and lw.

States, sequenced by an FSM:
- FETCH: hold imem_req=1 and imem_addr=pc until imem_ack. On ack, latch IR←imem_rdata and pc←pc+4.
- DECODE: latch A←R[rs], B←R[rt], and the sign-extended immediate. An illegal op/funct goes to HALT (HALT_ON_ILLEGAL=1) or retires as a NOP and returns to FETCH.
- EXEC, by instruction:
  - R-type/addi: latch ALUOut.
  - lw/sw: ALUOut←A+imm. A misaligned address (bits [1:0] ≠ 0) is treated like an illegal instruction.
  - beq: if A==B, pc←pc+(imm<<2), using the already-incremented pc. Retire, then FETCH.
  - j: pc←{pc[31:28], IR[25:0], 2'b00}. Retire, then FETCH.
- MEM: hold dmem_req=1, dmem_addr=ALUOut, dmem_we=(sw) until dmem_ack.
  - sw retires on ack, then FETCH.
  - lw latches MDR and goes to WB.
- WB: write ALUOut (R-type/addi) or MDR (lw) to the destination register. Retire, then FETCH.
- HALT: absorbing; no requests are issued. Only rst leaves it.

Request rules:
- req is never withdrawn before ack.
- Address, we and wdata stay stable while req is high.
- imem_req and dmem_req are never high in the same cycle.

## Timing

Latency with zero-wait memory (ack high in the first req cycle):

| Instruction | Cycles |
|---|---|
| beq, j | 3 |
| R-type, addi | 4 |
| sw | 4 |
| lw | 5 |

- Each wait cycle on a handshake adds one cycle.
- retire pulses in the cycle the FSM leaves its final state. instret increments on the following edge.
- A register written in WB is visible to DECODE of the next instruction (no hazards; multi-cycle).

Reset:
- While rst=1: pc=BOOT_ADDR, state=FETCH, imem_req=0, dmem_req=0, retire=0, instret=0, halted=0. Register contents are retained (not reset).
- The first fetch request is issued in the first cycle after rst deasserts.
- rst mid-handshake drops req on the next cycle. A late ack arriving while in FETCH after reset is not special-cased; the memory must not ack without a req.

## Structure
- Package yascm_pkg holds:
  - opcode constants OP_RTYPE/OP_ADDI/OP_LW/OP_SW/OP_BEQ/OP_J;
  - funct constants;
  - state enum FETCH/DECODE/EXEC/MEM/WB/HALT;
  - ALU op enum ADD/SUB/AND/OR/SLT.
- Sub-module yascm_regfile (2R1W, $0 hardwired). The ALU and FSM are inline.

## Test plan
1. Reset, BOOT_ADDR=0x100, zero-wait memory → first imem_addr=0x100 in the cycle after rst falls; instret=0 during reset.
2. addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 → R3=2, R4=1, instret=4 after 16 cycles.
3. sw $3,8($0); lw $5,8($0) → dmem write to 0x8 with data 2; R5=2; the store takes 4 cycles and the load 5.
4. beq taken with imm=-1 → pc returns to the branch itself (tight loop). beq not-taken → pc+4. j with target 0x40 → pc=0x40.
5. imem_ack delayed 3 cycles, with the address held stable throughout → R-type completes in 7 cycles; lw with dmem_ack delayed 2 cycles completes in 7 cycles.
6. Illegal op 0x3F, and lw at address 0x6:
   - HALT_ON_ILLEGAL=1 → halted=1, no further req; rst clears it.
   - HALT_ON_ILLEGAL=0 → retires as a NOP, instret increments, no dmem_req.
